// File: rtl/func_executor.sv
// func_executor: datapath and control unit of the simple processor.
// It decodes one 10-bit function word over R0..R7, the accumulator A and
// the ALU result G, and pulses Done in the final step of each word.
`timescale 1ns/1ps

module func_executor #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [9:0]   Func,
  input  logic [N-1:0] DIN,
  output logic         Done,
  output logic [N-1:0] BusWires,
  output logic         Z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  // One driver per state; ZERO is the idle value of the bus.
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_REG  = 2'd1,
    SEL_DIN  = 2'd2,
    SEL_G    = 2'd3
  } bus_sel_t;

  state_t         r_state;
  logic [9:0]     r_ir;
  logic [N-1:0]   r_regs [8];
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_g;
  logic           r_z;

  op_t            w_op;
  logic [2:0]     w_x;
  logic [2:0]     w_y;
  logic           w_is_arith;
  bus_sel_t       w_sel;
  logic [2:0]     w_ridx;
  logic [N-1:0]   w_bus;
  logic [N-1:0]   w_alu;
  logic           w_rx_we;
  logic           w_a_we;
  logic           w_g_we;
  logic           w_done;
  logic           w_unused_rsvd;

  // Field extraction from the latched word; Func itself is never used after IDLE.
  assign w_op       = op_t'(r_ir[9:8]);
  assign w_x        = r_ir[7:5];
  assign w_y        = r_ir[4:2];
  assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

  // Reserved function-word bits carry no meaning.
  assign w_unused_rsvd = ^r_ir[1:0];

  // Control decode: bus source and write enables from state plus IR op.
  always_comb begin
    w_sel   = SEL_ZERO;
    w_ridx  = w_y;
    w_rx_we = 1'b0;
    w_a_we  = 1'b0;
    w_g_we  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_sel = SEL_ZERO;
      end
      S_T1: begin
        unique case (w_op)
          OP_MV: begin
            w_sel   = SEL_REG;
            w_ridx  = w_y;
            w_rx_we = 1'b1;
            w_done  = 1'b1;
          end
          OP_MVI: begin
            w_sel   = SEL_DIN;
            w_rx_we = 1'b1;
            w_done  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_sel  = SEL_REG;
            w_ridx = w_x;
            w_a_we = 1'b1;
          end
          default: w_sel = SEL_ZERO;
        endcase
      end
      S_T2: begin
        w_sel  = SEL_REG;
        w_ridx = w_y;
        w_g_we = 1'b1;
      end
      S_T3: begin
        w_sel   = SEL_G;
        w_rx_we = 1'b1;
        w_done  = 1'b1;
      end
      default: w_sel = SEL_ZERO;
    endcase
  end

  // Shared bus multiplexer.
  always_comb begin
    w_bus = '0;
    unique case (w_sel)
      SEL_ZERO: w_bus = '0;
      SEL_REG:  w_bus = r_regs[w_ridx];
      SEL_DIN:  w_bus = DIN;
      SEL_G:    w_bus = r_g;
      default:  w_bus = '0;
    endcase
  end

  // ALU: modulo-2^N add or subtract of A and the bus.
  always_comb begin
    w_alu = '0;
    if (w_op == OP_SUB) begin
      w_alu = r_a - w_bus;
    end else begin
      w_alu = r_a + w_bus;
    end
  end

  assign BusWires = w_bus;
  assign Done     = w_done;
  assign Z        = r_z;

  // Sequencer: latch the word in IDLE, then step through T1..T3.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Run) begin
            r_ir    <= Func;
            r_state <= S_T1;
          end
        end
        S_T1:    r_state <= w_is_arith ? S_T2 : S_IDLE;
        S_T2:    r_state <= S_T3;
        S_T3:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Register file: Rx captures the bus on the edge that ends the Done step.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_regs <= '{default: '0};
    end else if (w_rx_we) begin
      r_regs[w_x] <= w_bus;
    end
  end

  // Accumulator, ALU result and zero flag; Z moves only with G.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_a <= '0;
      r_g <= '0;
      r_z <= 1'b0;
    end else begin
      if (w_a_we) begin
        r_a <= w_bus;
      end
      if (w_g_we) begin
        r_g <= w_alu;
        r_z <= (w_alu == '0);
      end
    end
  end

endmodule

// File: tb/tb_func_executor.sv
// Directed bench for func_executor with a per-cycle scoreboard.
`timescale 1ns/1ps

module tb_func_executor;

  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Resetn = 1'b0;
  logic         Run = 1'b0;
  logic [9:0]   Func = '0;
  logic [N-1:0] DIN = '0;
  logic         Done;
  logic [N-1:0] BusWires;
  logic         Z;

  func_executor #(.N(N)) dut (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .Run      (Run),
    .Func     (Func),
    .DIN      (DIN),
    .Done     (Done),
    .BusWires (BusWires),
    .Z        (Z)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    string        tag;
    logic         done;
    logic [N-1:0] bus;
    logic         z;
  } exp_t;

  exp_t         sb [$];
  int           done_at [$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] m_r [8];
  logic         m_z;

  localparam logic [1:0] MV = 2'b00, MVI = 2'b01, ADD = 2'b10, SUB = 2'b11;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input string tag, input logic d, input logic [N-1:0] b, input logic z);
    exp_t e;
    e.tag  = tag;
    e.done = d;
    e.bus  = b;
    e.z    = z;
    sb.push_back(e);
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".done"}, {{(N-1){1'b0}}, Done}, {{(N-1){1'b0}}, e.done});
      chk({e.tag, ".bus"},  BusWires, e.bus);
      chk({e.tag, ".z"},    {{(N-1){1'b0}}, Z}, {{(N-1){1'b0}}, e.z});
      if (Done === 1'b1) done_at.push_back(cyc);
    end
  endtask

  // Called at a negedge while the DUT is IDLE; issues one word, checks every
  // step plus the following IDLE cycle, and leaves the DUT IDLE again.
  task automatic word(input string tag, input logic [1:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic [N-1:0] din,
                      input bit keep, input bit disturb);
    int           n;
    logic [N-1:0] a, b, res;
    logic         nz;
    Run  = 1'b1;
    Func = {op, x, y, 2'b10};
    DIN  = din;
    case (op)
      MV: begin
        push({tag, "/T1"}, 1'b1, m_r[y], m_z);
        m_r[x] = m_r[y];
        n = 1;
      end
      MVI: begin
        push({tag, "/T1"}, 1'b1, din, m_z);
        m_r[x] = din;
        n = 1;
      end
      default: begin
        a   = m_r[x];
        b   = m_r[y];
        res = (op == SUB) ? a - b : a + b;
        nz  = (res == '0);
        push({tag, "/T1"}, 1'b0, a, m_z);
        push({tag, "/T2"}, 1'b0, b, m_z);
        push({tag, "/T3"}, 1'b1, res, nz);
        m_r[x] = res;
        m_z    = nz;
        n = 3;
      end
    endcase
    push({tag, "/idle"}, 1'b0, '0, m_z);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      pop_check();
      if (i == 0 && !keep) Run = 1'b0;
      if (disturb) begin
        if (i == 0) Func = {~Func[9:2], Func[1:0]};
        if (i == 1) Run = 1'b1;
        if (i == 2) Run = 1'b0;
      end
    end
    @(negedge Clk);
    pop_check();
    Run = 1'b0;
  endtask

  task automatic idle_cycle(input string tag);
    push(tag, 1'b0, '0, m_z);
    @(negedge Clk);
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    m_r = '{default: '0};
    m_z = 1'b0;

    // Reset state
    #12;
    chk("rst.done", {{(N-1){1'b0}}, Done}, '0);
    chk("rst.bus",  BusWires, '0);
    chk("rst.z",    {{(N-1){1'b0}}, Z}, '0);
    @(negedge Clk);
    Resetn = 1'b1;

    // mvi then mv; R3 read back through another mv
    word("mvi_r0",  MVI, 3'd0, 3'd0, 8'h5A, 1'b0, 1'b0);
    word("mv_r3r0", MV,  3'd3, 3'd0, 8'h00, 1'b0, 1'b0);
    word("rd_r3",   MV,  3'd6, 3'd3, 8'h00, 1'b0, 1'b0);

    // add with wrap
    word("mvi_r1",  MVI, 3'd1, 3'd0, 8'hF0, 1'b0, 1'b0);
    word("mvi_r2",  MVI, 3'd2, 3'd0, 8'h20, 1'b0, 1'b0);
    word("add_wrap", ADD, 3'd1, 3'd2, 8'h00, 1'b0, 1'b0);
    word("rd_r1",   MV,  3'd7, 3'd1, 8'h00, 1'b0, 1'b0);

    // sub to zero, then mvi keeps Z
    word("mvi_r4",  MVI, 3'd4, 3'd0, 8'h33, 1'b0, 1'b0);
    word("sub_r4",  SUB, 3'd4, 3'd4, 8'h00, 1'b0, 1'b0);
    word("mvi_r4b", MVI, 3'd4, 3'd0, 8'h01, 1'b0, 1'b0);
    word("rd_r4",   MV,  3'd0, 3'd4, 8'h00, 1'b0, 1'b0);

    // Run while busy plus Func change during T1
    word("add_busy", ADD, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1);
    idle_cycle("busy_noextra");
    word("rd_busy", MV,  3'd0, 3'd1, 8'h00, 1'b0, 1'b0);

    // Back-to-back with Run held high
    done_at.delete();
    word("b2b_mvi0", MVI, 3'd0, 3'd0, 8'h07, 1'b1, 1'b0);
    word("b2b_mvi5", MVI, 3'd5, 3'd0, 8'h99, 1'b1, 1'b0);
    word("b2b_add",  ADD, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0);
    chk("b2b.count", N'(done_at.size()), 8'd3);
    if (done_at.size() == 3) begin
      chk("b2b.gap_mvi", N'(done_at[1] - done_at[0]), 8'd2);
      chk("b2b.gap_add", N'(done_at[2] - done_at[1]), 8'd4);
    end
    word("rd_r0", MV, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0);

    // Reset asserted during T2 of an add, with Z previously set
    word("sub_r2", SUB, 3'd2, 3'd2, 8'h00, 1'b0, 1'b0);
    Run  = 1'b1;
    Func = {ADD, 3'd1, 3'd3, 2'b00};
    @(negedge Clk);
    chk("rstmid.T1.bus", BusWires, m_r[1]);
    Run = 1'b0;
    @(negedge Clk);
    chk("rstmid.T2.bus", BusWires, m_r[3]);
    #2;
    Resetn = 1'b0;
    #1;
    chk("rstmid.done", {{(N-1){1'b0}}, Done}, '0);
    chk("rstmid.bus",  BusWires, '0);
    chk("rstmid.z",    {{(N-1){1'b0}}, Z}, '0);
    m_r = '{default: '0};
    m_z = 1'b0;
    @(negedge Clk);
    chk("rstmid.hold.bus", BusWires, '0);
    Resetn = 1'b1;
    word("post_mv_r1r0", MV, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0);
    word("post_rd_r1",   MV, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0);
    word("post_rd_r3",   MV, 3'd6, 3'd3, 8'h00, 1'b0, 1'b0);
    idle_cycle("post_idle");

    chk("sb.drained", N'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
